settle_monitor: RTL and testbench



---
 rtl/settle_monitor.sv | 128 ++++++++++++
 tb/tb_settle_monitor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/settle_monitor.sv
// settle_monitor: watches a bank of same-clock cell outputs after a start
// request and reports when they have held constant for QUIET edges, along
// with the settled value and a saturating count of bit transitions seen.
// Flags a timeout when the bank fails to go quiet within MAXWAIT edges.
module settle_monitor #(
    parameter int WIDTH   = 8,
    parameter int QUIET   = 16,
    parameter int MAXWAIT = 1000
) (
    input  logic             U,
    input  logic             RESET,
    input  logic             start,
    input  logic [WIDTH-1:0] q_in,
    output logic             busy,
    output logic             settled,
    output logic             timeout,
    output logic [WIDTH-1:0] value,
    output logic [7:0]       glitches
);

    typedef enum logic [1:0] {IDLE, WATCH, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [9:0]       quiet_q, quiet_d;
    logic [11:0]      waitcnt_q, waitcnt_d;
    logic [7:0]       glitches_q, glitches_d;
    logic             settled_q, settled_d;
    logic             timeout_q, timeout_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             settle_fire;

    // Number of bits that differ between two consecutive samples.
    function automatic logic [8:0] popcount(input logic [WIDTH-1:0] v);
        logic [8:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + 9'(v[i]);
        end
        return cnt;
    endfunction

    // Add with a 9-bit intermediate and clamp so the count never wraps.
    function automatic logic [7:0] sat_add(input logic [7:0] acc, input logic [8:0] inc);
        logic [8:0] sum;
        sum = {1'b0, acc} + inc;
        return (sum > 9'd255) ? 8'd255 : sum[7:0];
    endfunction

    // Next-state logic: start handling in IDLE/DONE, settle/timeout tracking in WATCH.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        quiet_d     = quiet_q;
        waitcnt_d   = waitcnt_q;
        glitches_d  = glitches_q;
        settled_d   = settled_q;
        timeout_d   = timeout_q;
        value_d     = value_q;
        settle_fire = 1'b0;

        case (state_q)
            WATCH: begin
                waitcnt_d = waitcnt_q + 12'd1;
                if (q_in != prev_q) begin
                    prev_d     = q_in;
                    quiet_d    = '0;
                    glitches_d = sat_add(glitches_q, popcount(q_in ^ prev_q));
                end else if (quiet_q == 10'(QUIET - 1)) begin
                    settle_fire = 1'b1;
                    value_d     = q_in;
                    settled_d   = 1'b1;
                    state_d     = DONE;
                end else begin
                    quiet_d = quiet_q + 10'd1;
                end
                // Settling on the same edge as the deadline counts as a settle.
                if ((waitcnt_q == 12'(MAXWAIT - 1)) && !settle_fire) begin
                    value_d   = q_in;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept a new watch; start in WATCH is ignored.
                if (start) begin
                    prev_d     = q_in;
                    quiet_d    = '0;
                    waitcnt_d  = '0;
                    glitches_d = '0;
                    settled_d  = 1'b0;
                    timeout_d  = 1'b0;
                    state_d    = WATCH;
                end
            end
        endcase
    end

    // State and datapath registers; reset aborts any watch without reporting.
    always_ff @(posedge U or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            quiet_q    <= '0;
            waitcnt_q  <= '0;
            glitches_q <= '0;
            settled_q  <= 1'b0;
            timeout_q  <= 1'b0;
            value_q    <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            quiet_q    <= quiet_d;
            waitcnt_q  <= waitcnt_d;
            glitches_q <= glitches_d;
            settled_q  <= settled_d;
            timeout_q  <= timeout_d;
            value_q    <= value_d;
        end
    end

    assign busy     = (state_q == WATCH);
    assign settled  = settled_q;
    assign timeout  = timeout_q;
    assign value    = value_q;
    assign glitches = glitches_q;

endmodule

// File: tb/tb_settle_monitor.sv
// Directed bench for settle_monitor: default-parameter instance plus a
// short-deadline instance for the settle-versus-timeout tie.
module tb_settle_monitor;

    logic       U = 1'b0;
    logic       RESET;
    logic       start, start2;
    logic [7:0] q_in, q2;
    logic       busy, settled, timeout;
    logic [7:0] value, glitches;
    logic       busy2, settled2, timeout2;
    logic [7:0] value2, glitches2;

    int n_cmp = 0;
    int n_bad = 0;

    settle_monitor #(.WIDTH(8), .QUIET(16), .MAXWAIT(1000)) dut (
        .U(U), .RESET(RESET), .start(start), .q_in(q_in),
        .busy(busy), .settled(settled), .timeout(timeout),
        .value(value), .glitches(glitches)
    );

    settle_monitor #(.WIDTH(8), .QUIET(16), .MAXWAIT(17)) dut2 (
        .U(U), .RESET(RESET), .start(start2), .q_in(q2),
        .busy(busy2), .settled(settled2), .timeout(timeout2),
        .value(value2), .glitches(glitches2)
    );

    always #5 U = ~U;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n active edges; return 1 ns after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge U);
            #1;
        end
    endtask

    initial begin
        RESET  = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        q_in   = 8'h00;
        q2     = 8'h00;
        tick(2);
        RESET = 1'b0;
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_settled",  32'(settled),  32'd0);
        check("rst_timeout",  32'(timeout),  32'd0);
        check("rst_value",    32'(value),    32'h00);
        check("rst_glitches", 32'(glitches), 32'd0);

        // Stable 0xA5: settles after E16.
        q_in  = 8'hA5;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("t1_busy_e0",     32'(busy),    32'd1);
        tick(15);
        check("t1_settled_e15", 32'(settled), 32'd0);
        check("t1_busy_e15",    32'(busy),    32'd1);
        tick(1);
        check("t1_settled",  32'(settled),  32'd1);
        check("t1_busy",     32'(busy),     32'd0);
        check("t1_value",    32'(value),    32'hA5);
        check("t1_glitches", 32'(glitches), 32'd0);
        check("t1_timeout",  32'(timeout),  32'd0);

        // Single change 0x00 -> 0x01 before E5: settles after E21.
        q_in  = 8'h00;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("t2_settled_clr", 32'(settled), 32'd0);
        check("t2_value_hold",  32'(value),   32'hA5);
        tick(4);
        q_in = 8'h01;
        tick(16);
        check("t2_settled_e20", 32'(settled), 32'd0);
        tick(1);
        check("t2_settled",  32'(settled),  32'd1);
        check("t2_value",    32'(value),    32'h01);
        check("t2_glitches", 32'(glitches), 32'd1);

        // Toggle every edge: timeout after E1000, glitches saturate.
        q_in  = 8'h00;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int k = 1; k <= 999; k++) begin
            q_in = ~q_in;
            tick(1);
        end
        check("t3_timeout_e999", 32'(timeout), 32'd0);
        check("t3_busy_e999",    32'(busy),    32'd1);
        q_in = ~q_in;
        tick(1);
        check("t3_timeout",  32'(timeout),  32'd1);
        check("t3_settled",  32'(settled),  32'd0);
        check("t3_glitches", 32'(glitches), 32'd255);
        check("t3_value",    32'(value),    32'h00);
        check("t3_busy",     32'(busy),     32'd0);

        // MAXWAIT=17, one change at E1: settle and deadline meet at E17.
        q2     = 8'h00;
        start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
        q2 = 8'h3C;
        tick(1);
        tick(15);
        check("t4_settled_e16", 32'(settled2), 32'd0);
        check("t4_timeout_e16", 32'(timeout2), 32'd0);
        check("t4_busy_e16",    32'(busy2),    32'd1);
        tick(1);
        check("t4_settled",  32'(settled2),  32'd1);
        check("t4_timeout",  32'(timeout2),  32'd0);
        check("t4_value",    32'(value2),    32'h3C);
        check("t4_glitches", 32'(glitches2), 32'd4);

        // Reset after E8 of a watch aborts it; next watch is normal.
        q_in  = 8'h5A;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(8);
        check("t5_busy_e8", 32'(busy), 32'd1);
        #2 RESET = 1'b1;
        #1;
        check("t5_rst_busy",     32'(busy),     32'd0);
        check("t5_rst_settled",  32'(settled),  32'd0);
        check("t5_rst_timeout",  32'(timeout),  32'd0);
        check("t5_rst_value",    32'(value),    32'h00);
        check("t5_rst_glitches", 32'(glitches), 32'd0);
        #1 RESET = 1'b0;
        tick(3);
        check("t5_idle_busy",    32'(busy),    32'd0);
        check("t5_idle_settled", 32'(settled), 32'd0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(15);
        check("t5_settled_e15", 32'(settled), 32'd0);
        tick(1);
        check("t5_settled", 32'(settled), 32'd1);
        check("t5_value",   32'(value),   32'h5A);

        // Extra starts at E3 and E10 are ignored.
        q_in  = 8'hC3;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("t6_busy_e3", 32'(busy), 32'd1);
        tick(6);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(5);
        check("t6_settled_e15", 32'(settled), 32'd0);
        tick(1);
        check("t6_settled", 32'(settled), 32'd1);
        check("t6_value",   32'(value),   32'hC3);

        // Start in DONE clears settled and begins a new watch.
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("t7_settled_clr", 32'(settled),  32'd0);
        check("t7_busy",        32'(busy),     32'd1);
        check("t7_glitches",    32'(glitches), 32'd0);
        tick(16);
        check("t7_settled", 32'(settled), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
